// File: rtl/ext_int_arbiter.sv
// Four-source external interrupt front end: synchronize, debounce, latch rising
// edges as pending, and present the lowest enabled pending source to the core.
module ext_int_arbiter #(
    parameter int DEB_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] pinIn,
    input  logic [3:0] intEn,
    input  logic       intAck,
    output logic       intReq,
    output logic [1:0] intId,
    output logic [3:0] pendOut,
    output logic [3:0] levelOut
);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'(DEB_LEN - 1);

    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;
    logic [3:0] filt_vec;
    logic [3:0] rise_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= pinIn;
            sync2_reg <= sync1_reg;
        end
    end

    // Per-source debounce: filtered level follows sync only after DEB_LEN
    // consecutive disagreeing samples.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_deb
            logic [3:0] cnt_reg;
            logic [3:0] cnt_next;
            logic       filt_reg;
            logic       filt_next;
            logic       rise;

            always_comb begin
                cnt_next  = cnt_reg;
                filt_next = filt_reg;
                rise      = 1'b0;
                if (sync2_reg[gi] == filt_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg < CNT_MAX) begin
                    cnt_next = cnt_reg + 4'd1;
                end else begin
                    filt_next = sync2_reg[gi];
                    cnt_next  = '0;
                    rise      = sync2_reg[gi];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg  <= '0;
                    filt_reg <= 1'b0;
                end else begin
                    cnt_reg  <= cnt_next;
                    filt_reg <= filt_next;
                end
            end

            assign filt_vec[gi] = filt_reg;
            assign rise_vec[gi] = rise;
        end
    endgenerate

    state_t     state_reg;
    state_t     state_next;
    logic [1:0] id_reg;
    logic [1:0] id_next;
    logic [3:0] pend_reg;
    logic [3:0] pend_next;
    logic [3:0] pend_clr;
    logic [3:0] avail;

    assign avail = pend_reg & intEn;

    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        pend_clr   = '0;
        case (state_reg)
            IDLE: begin
                if (|avail) begin
                    state_next = REQ;
                    // Descending scan so the lowest set index is the one kept.
                    for (int k = 3; k >= 0; k--) begin
                        if (avail[k]) id_next = 2'(k);
                    end
                end
            end
            REQ: begin
                if (intAck) begin
                    state_next       = IDLE;
                    pend_clr[id_reg] = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // A new rising edge on the acknowledged source outranks its clear.
        pend_next = (pend_reg & ~pend_clr) | (rise_vec & intEn);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            id_reg    <= '0;
            pend_reg  <= '0;
        end else begin
            state_reg <= state_next;
            id_reg    <= id_next;
            pend_reg  <= pend_next;
        end
    end

    assign intReq   = (state_reg == REQ);
    assign intId    = id_reg;
    assign pendOut  = pend_reg;
    assign levelOut = filt_vec;

endmodule

// File: tb/tb_ext_int_arbiter.sv
// Bench for ext_int_arbiter: directed scenarios plus randomized traffic checked
// against a sample-history reference model.
module tb_ext_int_arbiter;

    localparam int DEB = 4;

    logic       clk;
    logic       rst;
    logic [3:0] pinIn;
    logic [3:0] intEn;
    logic       intAck;
    logic       intReq;
    logic [1:0] intId;
    logic [3:0] pendOut;
    logic [3:0] levelOut;

    int n_total = 0;
    int n_bad   = 0;

    ext_int_arbiter #(.DEB_LEN(DEB)) dut (
        .clk     (clk),
        .rst     (rst),
        .pinIn   (pinIn),
        .intEn   (intEn),
        .intAck  (intAck),
        .intReq  (intReq),
        .intId   (intId),
        .pendOut (pendOut),
        .levelOut(levelOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: pins reach logic two edges late; a level flips once the
    // last DEB samples taken since the previous flip all disagree with it.
    logic [3:0]  m_s1, m_s2, m_filt, m_pend;
    logic [15:0] m_hist [4];
    int          m_since [4];
    logic        m_busy;
    logic [1:0]  m_id;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_filt = '0; m_pend = '0;
        m_busy = 1'b0; m_id = '0;
        for (int i = 0; i < 4; i++) begin
            m_hist[i]  = '0;
            m_since[i] = 0;
        end
    endtask

    task automatic model_tick();
        logic [3:0] seen, set_v, clr_v, avail;
        logic       all_diff, found;
        seen  = m_s2;
        m_s2  = m_s1;
        m_s1  = pinIn;
        set_v = '0;
        clr_v = '0;
        for (int i = 0; i < 4; i++) begin
            m_hist[i] = {m_hist[i][14:0], seen[i]};
            m_since[i]++;
            all_diff = 1'b1;
            for (int k = 0; k < DEB; k++)
                if (m_hist[i][k] == m_filt[i]) all_diff = 1'b0;
            if (m_since[i] >= DEB && all_diff) begin
                m_filt[i]  = seen[i];
                m_since[i] = 0;
                if (seen[i] && intEn[i]) set_v[i] = 1'b1;
            end
        end
        avail = m_pend & intEn;
        if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (avail[k] && !found) begin
                    m_id  = 2'(k);
                    found = 1'b1;
                end
            end
            m_busy = found;
        end else if (intAck) begin
            clr_v[m_id] = 1'b1;
            m_busy      = 1'b0;
        end
        m_pend = (m_pend & ~clr_v) | set_v;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; pinIn = '0; intEn = '0; intAck = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pinIn = '0; intEn = 4'hF; intAck = 1'b0;
        model_reset();
        #1;
        n_total++;
        if ({intReq, intId, pendOut, levelOut} !== 11'b0) begin
            n_bad++;
            $display("FAIL reset_hold: got req=%b id=%0d pend=%b lvl=%b want all zero",
                     intReq, intId, pendOut, levelOut);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cycle();
        n_total++;
        if ({intReq, intId, pendOut, levelOut} !== 11'b0) begin
            n_bad++;
            $display("FAIL reset_release: got req=%b id=%0d pend=%b lvl=%b want all zero",
                     intReq, intId, pendOut, levelOut);
        end
        $display("txn reset checked");
    endtask

    task automatic test_level_timing();
        do_reset();
        intEn = 4'hF;
        pinIn = 4'b0100;
        repeat (5) cycle();
        n_total++;
        if (levelOut !== 4'b0000) begin
            n_bad++;
            $display("FAIL level_early: got lvl=%b want 0000 after edge 5", levelOut);
        end
        cycle();
        n_total++;
        if (levelOut !== 4'b0100 || pendOut !== 4'b0100 || intReq !== 1'b0) begin
            n_bad++;
            $display("FAIL level_edge6: got lvl=%b pend=%b req=%b want 0100 0100 0",
                     levelOut, pendOut, intReq);
        end
        cycle();
        n_total++;
        if (intReq !== 1'b1 || intId !== 2'd2) begin
            n_bad++;
            $display("FAIL req_edge7: got req=%b id=%0d want 1 2", intReq, intId);
        end
        intAck = 1'b1;
        cycle();
        intAck = 1'b0;
        n_total++;
        if (intReq !== 1'b0 || pendOut !== 4'b0000) begin
            n_bad++;
            $display("FAIL ack_single: got req=%b pend=%b want 0 0000", intReq, pendOut);
        end
        $display("txn level timing id=2 acked");
    endtask

    task automatic test_glitch();
        do_reset();
        intEn = 4'hF;
        pinIn = 4'b0001;
        repeat (3) cycle();
        pinIn = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            cycle();
            n_total++;
            if (levelOut !== 4'b0000 || pendOut !== 4'b0000 || intReq !== 1'b0) begin
                n_bad++;
                $display("FAIL glitch c%0d: got lvl=%b pend=%b req=%b want 0000 0000 0",
                         c, levelOut, pendOut, intReq);
            end
        end
        $display("txn glitch rejected");
    endtask

    task automatic test_priority();
        do_reset();
        intEn = 4'hF;
        pinIn = 4'b1010;
        repeat (6) cycle();
        n_total++;
        if (pendOut !== 4'b1010) begin
            n_bad++;
            $display("FAIL prio_pend: got pend=%b want 1010", pendOut);
        end
        cycle();
        n_total++;
        if (intReq !== 1'b1 || intId !== 2'd1) begin
            n_bad++;
            $display("FAIL prio_first: got req=%b id=%0d want 1 1", intReq, intId);
        end
        intAck = 1'b1;
        cycle();
        intAck = 1'b0;
        n_total++;
        if (pendOut !== 4'b1000 || intReq !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_gap: got pend=%b req=%b want 1000 0", pendOut, intReq);
        end
        cycle();
        n_total++;
        if (intReq !== 1'b1 || intId !== 2'd3) begin
            n_bad++;
            $display("FAIL prio_second: got req=%b id=%0d want 1 3", intReq, intId);
        end
        intAck = 1'b1;
        cycle();
        intAck = 1'b0;
        n_total++;
        if (pendOut !== 4'b0000 || intReq !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_done: got pend=%b req=%b want 0000 0", pendOut, intReq);
        end
        $display("txn priority ids 1 then 3 acked");
    endtask

    task automatic test_enable();
        do_reset();
        intEn = 4'b1110;
        pinIn = 4'b0001;
        repeat (8) cycle();
        n_total++;
        if (pendOut !== 4'b0000 || intReq !== 1'b0 || levelOut !== 4'b0001) begin
            n_bad++;
            $display("FAIL en_discard: got pend=%b req=%b lvl=%b want 0000 0 0001",
                     pendOut, intReq, levelOut);
        end
        do_reset();
        intEn = 4'hF;
        pinIn = 4'b0001;
        repeat (6) cycle();
        intEn  = 4'b1110;
        intAck = 1'b1;
        repeat (4) cycle();
        intAck = 1'b0;
        n_total++;
        if (pendOut !== 4'b0001 || intReq !== 1'b0) begin
            n_bad++;
            $display("FAIL en_masked: got pend=%b req=%b want 0001 0", pendOut, intReq);
        end
        intEn = 4'hF;
        cycle();
        n_total++;
        if (intReq !== 1'b1 || intId !== 2'd0) begin
            n_bad++;
            $display("FAIL en_restore: got req=%b id=%0d want 1 0", intReq, intId);
        end
        intAck = 1'b1;
        cycle();
        intAck = 1'b0;
        $display("txn enable mask id=0 acked");
    endtask

    task automatic test_set_wins();
        do_reset();
        intEn = 4'hF;
        pinIn = 4'b0010;
        repeat (7) cycle();
        n_total++;
        if (intReq !== 1'b1 || intId !== 2'd1) begin
            n_bad++;
            $display("FAIL sw_req: got req=%b id=%0d want 1 1", intReq, intId);
        end
        intEn = 4'b1101;
        pinIn = 4'b0000;
        repeat (8) cycle();
        n_total++;
        if (intReq !== 1'b1 || intId !== 2'd1 || levelOut !== 4'b0000) begin
            n_bad++;
            $display("FAIL sw_hold: got req=%b id=%0d lvl=%b want 1 1 0000",
                     intReq, intId, levelOut);
        end
        intEn = 4'hF;
        pinIn = 4'b0010;
        repeat (5) cycle();
        intAck = 1'b1;
        cycle();
        intAck = 1'b0;
        n_total++;
        if (pendOut !== 4'b0010 || intReq !== 1'b0 || levelOut !== 4'b0010) begin
            n_bad++;
            $display("FAIL sw_collide: got pend=%b req=%b lvl=%b want 0010 0 0010",
                     pendOut, intReq, levelOut);
        end
        cycle();
        n_total++;
        if (intReq !== 1'b1 || intId !== 2'd1) begin
            n_bad++;
            $display("FAIL sw_rerequest: got req=%b id=%0d want 1 1", intReq, intId);
        end
        intAck = 1'b1;
        cycle();
        intAck = 1'b0;
        $display("txn set-wins id=1 acked twice");
    endtask

    task automatic test_async_reset();
        do_reset();
        intEn = 4'hF;
        pinIn = 4'b0110;
        repeat (7) cycle();
        n_total++;
        if (intReq !== 1'b1 || pendOut !== 4'b0110) begin
            n_bad++;
            $display("FAIL ar_setup: got req=%b pend=%b want 1 0110", intReq, pendOut);
        end
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (intReq !== 1'b0 || pendOut !== 4'b0000 || levelOut !== 4'b0000) begin
            n_bad++;
            $display("FAIL ar_immediate: got req=%b pend=%b lvl=%b want 0 0000 0000",
                     intReq, pendOut, levelOut);
        end
        model_reset();
        pinIn = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            n_total++;
            if (intReq !== 1'b0 || pendOut !== 4'b0000) begin
                n_bad++;
                $display("FAIL ar_quiet c%0d: got req=%b pend=%b want 0 0000",
                         c, intReq, pendOut);
            end
        end
        $display("txn async reset mid-request");
    endtask

    task automatic test_random();
        int hold [4];
        do_reset();
        intEn = 4'hF;
        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    pinIn[i] = 1'($urandom_range(0, 1));
                    hold[i]  = $urandom_range(1, 9);
                end else begin
                    hold[i]--;
                end
            end
            if ($urandom_range(0, 19) == 0) intEn = 4'($urandom_range(0, 15));
            intAck = ($urandom_range(0, 2) == 0);
            if (intAck && m_busy) $display("txn random ack id=%0d cycle=%0d", m_id, c);
            cycle();
            n_total++;
            if ({intReq, intId, pendOut, levelOut} !== {m_busy, m_id, m_pend, m_filt}) begin
                n_bad++;
                $display("FAIL rand c%0d: got req=%b id=%0d pend=%b lvl=%b want req=%b id=%0d pend=%b lvl=%b",
                         c, intReq, intId, pendOut, levelOut, m_busy, m_id, m_pend, m_filt);
            end
        end
        intAck = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pinIn = '0; intEn = '0; intAck = 1'b0;
        model_reset();
        test_reset();
        test_level_timing();
        test_glitch();
        test_priority();
        test_enable();
        test_set_wins();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
